// File: rtl/vram_arbiter.sv
// Slot-based VRAM arbiter: video owns phases 0/4 while displaying, CPU and DMA share the rest.
// Optional DMA requester compiled in with `define VRAM_ARB_DMA_EN.
module vram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_6mp,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr0,
  input  logic [ADDR_W-1:0] vid_addr1,
  output logic [DATA_W-1:0] vid_data0,
  output logic [DATA_W-1:0] vid_data1,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_wait,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [2:0]        phase
);

  typedef enum logic [1:0] {OWN_VID0, OWN_VID1, OWN_CPU, OWN_DMA} owner_t;
  // The ce_6mp cycle seen in IDLE is the issue cycle; RETURN is the cycle ram_dout is valid.
  typedef enum logic {IDLE, RETURN} state_t;

  state_t              state;
  owner_t              owner_p0, owner_p1;
  logic                issue_p0, we_p0, we_p1;
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   din_p0;
  logic                cpu_pend, dma_pend, vid_slot, prefer_dma;
  logic                cpu_ack_p1;
  logic [DATA_W-1:0]   cpu_rdata_q;

`ifdef VRAM_ARB_DMA_EN
  logic                dma_ack_p1;
  logic [DATA_W-1:0]   dma_rdata_q;
  assign dma_ack   = dma_ack_p1 & ~reset;
  assign dma_rdata = (dma_ack && !we_p1) ? ram_dout : dma_rdata_q;
  assign dma_pend  = dma_req & ~dma_ack;
`else
  logic dma_unused;
  assign dma_unused = ^{dma_req, dma_we, dma_addr, dma_wdata};
  assign dma_ack    = 1'b0;
  assign dma_rdata  = '0;
  assign dma_pend   = 1'b0;
`endif

  assign cpu_ack   = cpu_ack_p1 & ~reset;
  assign cpu_wait  = cpu_req & ~cpu_ack;
  assign cpu_rdata = (cpu_ack && !we_p1) ? ram_dout : cpu_rdata_q;
  assign cpu_pend  = cpu_req & ~cpu_ack;
  assign vid_slot  = vid_active & (phase[1:0] == 2'b00);

  // p0: slot decision in the ce_6mp cycle
  always_comb begin
    issue_p0 = 1'b0;
    owner_p0 = OWN_CPU;
    addr_p0  = '0;
    we_p0    = 1'b0;
    din_p0   = '0;
    if (ce_6mp && !reset) begin
      if (vid_slot) begin
        issue_p0 = 1'b1;
        owner_p0 = phase[2] ? OWN_VID1 : OWN_VID0;
        addr_p0  = phase[2] ? vid_addr1 : vid_addr0;
      end else if (cpu_pend && !(dma_pend && prefer_dma)) begin
        issue_p0 = 1'b1;
        owner_p0 = OWN_CPU;
        addr_p0  = cpu_addr;
        we_p0    = cpu_we;
        din_p0   = cpu_wdata;
`ifdef VRAM_ARB_DMA_EN
      end else if (dma_pend) begin
        issue_p0 = 1'b1;
        owner_p0 = OWN_DMA;
        addr_p0  = dma_addr;
        we_p0    = dma_we;
        din_p0   = dma_wdata;
`endif
      end
    end
  end

  assign ram_cs   = issue_p0;
  assign ram_we   = we_p0;
  assign ram_addr = addr_p0;
  assign ram_din  = din_p0;

  // p1: owner registered, ack pulsed, returned data routed at the end of RETURN
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      phase       <= 3'd0;
      state       <= IDLE;
      prefer_dma  <= 1'b0;
      cpu_ack_p1  <= 1'b0;
      cpu_rdata_q <= '0;
      vid_data0   <= '0;
      vid_data1   <= '0;
`ifdef VRAM_ARB_DMA_EN
      dma_ack_p1  <= 1'b0;
      dma_rdata_q <= '0;
`endif
    end else begin
      if (ce_6mp) phase <= phase + 3'd1;
      state      <= issue_p0 ? RETURN : IDLE;
      cpu_ack_p1 <= issue_p0 && (owner_p0 == OWN_CPU);
`ifdef VRAM_ARB_DMA_EN
      dma_ack_p1 <= issue_p0 && (owner_p0 == OWN_DMA);
`endif
      if (issue_p0) begin
        owner_p1 <= owner_p0;
        we_p1    <= we_p0;
        if (owner_p0 == OWN_CPU) prefer_dma <= 1'b1;
        if (owner_p0 == OWN_DMA) prefer_dma <= 1'b0;
      end
      if (state == RETURN) begin
        case (owner_p1)
          OWN_VID0: vid_data0 <= ram_dout;
          OWN_VID1: vid_data1 <= ram_dout;
          OWN_CPU:  if (!we_p1) cpu_rdata_q <= ram_dout;
`ifdef VRAM_ARB_DMA_EN
          OWN_DMA:  if (!we_p1) dma_rdata_q <= ram_dout;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule
